// File: rtl/runway_traffic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : runway_traffic_arbiter
// Description : Queues landing/takeoff requests and grants exclusive use of a
//               single runway for a fixed occupancy time. Takeoffs are held in
//               HIGH_ALERT, rejected and flushed in EMERGENCY. Landings have
//               priority, but a waiting takeoff wins after FAIR_LIMIT
//               consecutive landing grants.
// Revision    : 1.0 - initial release
// ============================================================================
module runway_traffic_arbiter #(
  parameter int DEPTH       = 4,
  parameter int LAND_CYCLES = 4,
  parameter int TKOF_CYCLES = 3,
  parameter int FAIR_LIMIT  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] ECSU_state,
  input  logic       landing_req,
  input  logic       takeoff_req,
  output logic       landing_grant,
  output logic       takeoff_grant,
  output logic       runway_busy,
  output logic [2:0] lq_count,
  output logic [2:0] tq_count,
  output logic       req_dropped,
  output logic [1:0] arb_state
);

  // Timer holds (occupancy - 1), so it needs enough bits for max(cycles) - 1.
  localparam int c_tmr_max = (LAND_CYCLES > TKOF_CYCLES) ? LAND_CYCLES : TKOF_CYCLES;
  localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;
  localparam int c_fair_w  = $clog2(FAIR_LIMIT + 1);

  localparam logic [2:0]          c_depth     = 3'(DEPTH);
  localparam logic [c_tmr_w-1:0]  c_land_load = c_tmr_w'(LAND_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]  c_tkof_load = c_tmr_w'(TKOF_CYCLES - 1);
  localparam logic [c_fair_w-1:0] c_fair_lim  = c_fair_w'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LANDING = 2'b01,
    S_TAKEOFF = 2'b10
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [c_tmr_w-1:0]  r_timer,  w_timer_nxt;
  logic [c_fair_w-1:0] r_fair,   w_fair_nxt;
  logic [2:0]          r_lq,     w_lq_nxt;
  logic [2:0]          r_tq,     w_tq_nxt;
  logic                r_lg,     w_lg;
  logic                r_tg,     w_tg;
  logic                r_drop,   w_drop;

  logic w_emerg;
  logic w_tk_elig;
  logic w_l_acc;
  logic w_t_acc;

  // Weather classification and request acceptance against pre-edge counts.
  always_comb begin
    w_emerg   = (ECSU_state == 2'b11);
    w_tk_elig = ~ECSU_state[1];
    w_l_acc   = landing_req && (r_lq < c_depth);
    w_t_acc   = takeoff_req && !w_emerg && (r_tq < c_depth);
  end

  // Arbitration and occupancy timer: grants only from IDLE, operations run to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_lg        = 1'b0;
    w_tg        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tk_elig && (r_tq != 3'd0) && ((r_lq == 3'd0) || (r_fair == c_fair_lim))) begin
          w_tg        = 1'b1;
          w_state_nxt = S_TAKEOFF;
          w_timer_nxt = c_tkof_load;
        end else if (r_lq != 3'd0) begin
          w_lg        = 1'b1;
          w_state_nxt = S_LANDING;
          w_timer_nxt = c_land_load;
        end
      end
      S_LANDING, S_TAKEOFF: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - c_tmr_w'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Queue counts, drop indication and fairness counter.
  always_comb begin
    w_lq_nxt = r_lq;
    if (w_l_acc) w_lq_nxt = w_lq_nxt + 3'd1;
    if (w_lg)    w_lq_nxt = w_lq_nxt - 3'd1;

    // EMERGENCY flushes the takeoff queue; no takeoff can be granted then.
    w_tq_nxt = r_tq;
    if (w_emerg) begin
      w_tq_nxt = 3'd0;
    end else begin
      if (w_t_acc) w_tq_nxt = w_tq_nxt + 3'd1;
      if (w_tg)    w_tq_nxt = w_tq_nxt - 3'd1;
    end

    w_drop = (landing_req && !w_l_acc) ||
             (takeoff_req && !w_t_acc) ||
             (w_emerg && (r_tq != 3'd0));

    // Fairness only matters while a takeoff waits, so it clears with the queue.
    w_fair_nxt = r_fair;
    if (w_tg || (w_tq_nxt == 3'd0)) begin
      w_fair_nxt = '0;
    end else if (w_lg && (r_fair != c_fair_lim)) begin
      w_fair_nxt = r_fair + c_fair_w'(1);
    end
  end

  // State, counters and registered output pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_fair  <= '0;
      r_lq    <= 3'd0;
      r_tq    <= 3'd0;
      r_lg    <= 1'b0;
      r_tg    <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_fair  <= w_fair_nxt;
      r_lq    <= w_lq_nxt;
      r_tq    <= w_tq_nxt;
      r_lg    <= w_lg;
      r_tg    <= w_tg;
      r_drop  <= w_drop;
    end
  end

  assign landing_grant = r_lg;
  assign takeoff_grant = r_tg;
  assign req_dropped   = r_drop;
  assign lq_count      = r_lq;
  assign tq_count      = r_tq;
  assign arb_state     = r_state;
  assign runway_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_runway_traffic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_runway_traffic_arbiter
// Description : Self-checking bench for runway_traffic_arbiter: vector table,
//               directed multi-cycle sequences and randomized traffic compared
//               against a queue/countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_runway_traffic_arbiter;

  localparam int DEPTH       = 4;
  localparam int LAND_CYCLES = 4;
  localparam int TKOF_CYCLES = 3;
  localparam int FAIR_LIMIT  = 3;

  logic       CLK;
  logic       RST;
  logic [1:0] ECSU_state;
  logic       landing_req;
  logic       takeoff_req;
  logic       landing_grant;
  logic       takeoff_grant;
  logic       runway_busy;
  logic [2:0] lq_count;
  logic [2:0] tq_count;
  logic       req_dropped;
  logic [1:0] arb_state;

  runway_traffic_arbiter #(
    .DEPTH      (DEPTH),
    .LAND_CYCLES(LAND_CYCLES),
    .TKOF_CYCLES(TKOF_CYCLES),
    .FAIR_LIMIT (FAIR_LIMIT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ECSU_state   (ECSU_state),
    .landing_req  (landing_req),
    .takeoff_req  (takeoff_req),
    .landing_grant(landing_grant),
    .takeoff_grant(takeoff_grant),
    .runway_busy  (runway_busy),
    .lq_count     (lq_count),
    .tq_count     (tq_count),
    .req_dropped  (req_dropped),
    .arb_state    (arb_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: queue sizes, fairness tally and remaining busy cycles.
  int m_lq, m_tq, m_fair, m_left, m_kind;
  int m_lg, m_tg, m_drop;

  string order;
  int    tg_cnt;

  typedef struct {
    bit       rst_n;
    bit [1:0] ec;
    bit       lr, tr;
    int       lg, tg, busy, lq, tq, drop, st;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit [1:0] ec, input bit lr, input bit tr);
    int nlq, ntq;
    int lg, tg, drop;
    lg = 0; tg = 0; drop = 0;
    if (!rst_n) begin
      m_lq = 0; m_tq = 0; m_fair = 0; m_left = 0; m_kind = 0;
      m_lg = 0; m_tg = 0; m_drop = 0;
      return;
    end
    if (m_left == 0) begin
      if (ec < 2 && m_tq > 0 && (m_lq == 0 || m_fair == FAIR_LIMIT)) tg = 1;
      else if (m_lq > 0) lg = 1;
    end else begin
      m_left--;
    end
    if (tg) begin m_left = TKOF_CYCLES; m_kind = 2; end
    if (lg) begin m_left = LAND_CYCLES; m_kind = 1; end

    nlq = m_lq;
    if (lr) begin
      if (m_lq < DEPTH) nlq++;
      else drop = 1;
    end
    if (lg) nlq--;

    ntq = m_tq;
    if (ec == 3) begin
      if (tr) drop = 1;
      if (m_tq > 0) begin drop = 1; ntq = 0; end
    end else begin
      if (tr) begin
        if (m_tq < DEPTH) ntq++;
        else drop = 1;
      end
      if (tg) ntq--;
    end

    if (tg) m_fair = 0;
    else if (lg && m_fair < FAIR_LIMIT) m_fair++;
    if (ntq == 0) m_fair = 0;

    m_lq = nlq; m_tq = ntq;
    m_lg = lg; m_tg = tg; m_drop = drop;
  endtask

  task automatic check_model();
    chk("landing_grant", landing_grant, m_lg);
    chk("takeoff_grant", takeoff_grant, m_tg);
    chk("req_dropped",   req_dropped,   m_drop);
    chk("runway_busy",   runway_busy,   (m_left > 0) ? 1 : 0);
    chk("arb_state",     arb_state,     (m_left > 0) ? m_kind : 0);
    chk("lq_count",      lq_count,      m_lq);
    chk("tq_count",      tq_count,      m_tq);
  endtask

  // Apply one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input bit rst_n, input bit [1:0] ec, input bit lr, input bit tr);
    RST = rst_n; ECSU_state = ec; landing_req = lr; takeoff_req = tr;
    @(posedge CLK);
    model_edge(rst_n, ec, lr, tr);
    #1;
    check_model();
    if (landing_grant) order = {order, "L"};
    if (takeoff_grant) begin order = {order, "T"}; tg_cnt++; end
  endtask

  task automatic addv(input bit r, input bit [1:0] ec, input bit lr, input bit tr,
                      input int lg, input int tg, input int busy, input int lq,
                      input int tq, input int drop, input int st);
    vec_t v;
    v.rst_n = r; v.ec = ec; v.lr = lr; v.tr = tr;
    v.lg = lg; v.tg = tg; v.busy = busy; v.lq = lq; v.tq = tq; v.drop = drop; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    RST = 1'b0; ECSU_state = 2'b00; landing_req = 1'b0; takeoff_req = 1'b0;
    order = ""; tg_cnt = 0;
    model_edge(1'b0, 2'b00, 1'b0, 1'b0);

    //     rst ec lr tr | lg tg busy lq tq drop st
    addv(0, 0, 1, 1,    0, 0, 0, 0, 0, 0, 0);  // reset with requests active
    addv(0, 0, 1, 1,    0, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 1, 0,    0, 0, 0, 1, 0, 0, 0);  // single landing accepted
    addv(1, 0, 0, 0,    1, 0, 1, 0, 0, 0, 1);  // granted next edge
    addv(1, 0, 0, 0,    0, 0, 1, 0, 0, 0, 1);
    addv(1, 0, 0, 0,    0, 0, 1, 0, 0, 0, 1);
    addv(1, 0, 0, 0,    0, 0, 1, 0, 0, 0, 1);  // 4th busy cycle
    addv(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);  // back to IDLE
    addv(1, 0, 1, 0,    0, 0, 0, 1, 0, 0, 0);  // overflow run starts
    addv(1, 0, 1, 0,    1, 0, 1, 1, 0, 0, 1);
    addv(1, 0, 1, 0,    0, 0, 1, 2, 0, 0, 1);
    addv(1, 0, 1, 0,    0, 0, 1, 3, 0, 0, 1);
    addv(1, 0, 1, 0,    0, 0, 1, 4, 0, 0, 1);  // full
    addv(1, 0, 1, 0,    0, 0, 0, 4, 0, 1, 0);  // 5th request dropped
    addv(1, 0, 1, 0,    1, 0, 1, 3, 0, 1, 1);  // grant does not free space
    addv(1, 0, 0, 0,    0, 0, 1, 3, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      RST = vq[i].rst_n; ECSU_state = vq[i].ec;
      landing_req = vq[i].lr; takeoff_req = vq[i].tr;
      @(posedge CLK);
      model_edge(vq[i].rst_n, vq[i].ec, vq[i].lr, vq[i].tr);
      #1;
      chk($sformatf("v%0d landing_grant", i), landing_grant, vq[i].lg);
      chk($sformatf("v%0d takeoff_grant", i), takeoff_grant, vq[i].tg);
      chk($sformatf("v%0d runway_busy", i),   runway_busy,   vq[i].busy);
      chk($sformatf("v%0d lq_count", i),      lq_count,      vq[i].lq);
      chk($sformatf("v%0d tq_count", i),      tq_count,      vq[i].tq);
      chk($sformatf("v%0d req_dropped", i),   req_dropped,   vq[i].drop);
      chk($sformatf("v%0d arb_state", i),     arb_state,     vq[i].st);
    end

    // Drain the remaining landings.
    repeat (25) step(1, 0, 0, 0);

    // Fairness: 5 landings and 1 takeoff queued under ALL_CLEAR.
    order = "";
    step(1, 0, 1, 1);
    repeat (4) step(1, 0, 1, 0);
    repeat (28) step(1, 0, 0, 0);
    checks++;
    if (order != "LLLTLL") begin
      errors++;
      $display("FAIL grant_order actual=%s expected=LLLTLL", order);
    end

    // HIGH_ALERT holds takeoffs; ALL_CLEAR releases them.
    tg_cnt = 0;
    step(1, 2, 0, 1);
    step(1, 2, 0, 1);
    repeat (6) step(1, 2, 0, 0);
    chk("high_alert tq_held", tq_count, 2);
    chk("high_alert no_grant", tg_cnt, 0);
    step(1, 0, 0, 0);
    chk("release takeoff_grant", takeoff_grant, 1);
    chk("release tq_count", tq_count, 1);
    repeat (10) step(1, 0, 0, 0);

    // EMERGENCY one cycle after a takeoff grant.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("emg takeoff_grant", takeoff_grant, 1);
    step(1, 0, 1, 1);
    chk("emg tq_before", tq_count, 2);
    chk("emg lq_before", lq_count, 1);
    step(1, 3, 0, 0);
    chk("emg tq_flushed", tq_count, 0);
    chk("emg flush_drop", req_dropped, 1);
    chk("emg still_busy", runway_busy, 1);
    step(1, 3, 0, 0);
    chk("emg takeoff_done", runway_busy, 0);
    step(1, 3, 0, 0);
    chk("emg landing_grant", landing_grant, 1);
    step(1, 3, 0, 1);
    chk("emg takeoff_rejected", req_dropped, 1);
    chk("emg tq_stays_0", tq_count, 0);
    repeat (6) step(1, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit       r;
      bit [1:0] ec;
      r  = ($urandom_range(0, 79) != 0);
      ec = ($urandom_range(0, 7) < 4) ? 2'b00 : 2'($urandom_range(0, 3));
      step(r, ec, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
